// File: rtl/fetch_pc_sequencer_pkg.sv
// fetch_pc_sequencer_pkg: shared reset PC, state encodings and widths for the fetch PC sequencer.
package fetch_pc_sequencer_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
    localparam int INST_NUM = 4;
    localparam int SINGLE_WORD = 32;
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DSLOT = 2'd2
    } fetchState_e;
endpackage

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: IF-stage PC generator with delay-slot sequencing and backend redirects.
// Define FETCH_PERF_CNT_EN to add saturating redirect/delay-slot/stall performance counters.
module fetch_pc_sequencer
    import fetch_pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int ADDR_W = SINGLE_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetchReady_i,
    output logic                fetchValid_o,
    output logic [ADDR_W-1:0]   fetchPC_o,
    output logic [INST_NUM-1:0] originEnable_o,
    output logic [ADDR_W-1:0]   fifthPC_o,
    output logic                inDelaySlot_o,
    input  logic [ADDR_W-1:0]   validDest_i,
    input  logic                validTake_i,
    input  logic                needDelaySlot_i,
    input  logic                redirectValid_i,
    input  logic [ADDR_W-1:0]   redirectPC_i
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perfRedirects_o,
    output logic [31:0]         perfDslotGroups_o,
    output logic [31:0]         perfStallCycles_o
`endif
);
    fetchState_e state, stateNext;
    logic [ADDR_W-1:0] pc, pcNext, pendTgt, pendNext, destAligned;
    logic accept;

    assign fetchPC_o = pc;
    assign fifthPC_o = {pc[ADDR_W-1:4] + (ADDR_W-4)'(1), 4'b0000};
    assign fetchValid_o = (state != BOOT) && !redirectValid_i;
    assign accept = fetchValid_o && fetchReady_i;
    assign inDelaySlot_o = (state == DSLOT);
    assign originEnable_o = (state == RUN) ? 4'b1111 << pc[3:2] : (state == DSLOT) ? 4'b0001 : 4'b0000;
    assign destAligned = validDest_i & ~ADDR_W'(3);

    always_comb begin
        stateNext = state;
        pcNext = pc;
        pendNext = pendTgt;
        if (redirectValid_i) begin
            stateNext = RUN;
            pcNext = redirectPC_i & ~ADDR_W'(3);
            pendNext = '0;
        end else if (state == BOOT) begin
            stateNext = RUN;
        end else if (accept) begin
            if (state == DSLOT) begin
                stateNext = RUN;
                pcNext = pendTgt;
            end else if (needDelaySlot_i) begin
                // Fetch the slot-3 branch's delay slot first; the target waits in pendTgt.
                stateNext = DSLOT;
                pcNext = fifthPC_o;
                pendNext = destAligned;
            end else if (validTake_i) begin
                pcNext = destAligned;
            end else begin
                pcNext = destAligned;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc <= RESET_PC;
            pendTgt <= '0;
        end else begin
            state <= stateNext;
            pc <= pcNext;
            pendTgt <= pendNext;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfRedirects_o <= '0;
            perfDslotGroups_o <= '0;
            perfStallCycles_o <= '0;
        end else begin
            if (redirectValid_i && ~&perfRedirects_o) perfRedirects_o <= perfRedirects_o + 32'd1;
            if (accept && state == DSLOT && ~&perfDslotGroups_o) perfDslotGroups_o <= perfDslotGroups_o + 32'd1;
            if (fetchValid_o && !fetchReady_i && ~&perfStallCycles_o) perfStallCycles_o <= perfStallCycles_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// tb_fetch_pc_sequencer: directed and random checks of fetch_pc_sequencer against a behavioural model.
module tb_fetch_pc_sequencer;
    logic clk = 0, rst_n = 0;
    logic fetchReady = 0, validTake = 0, needDs = 0, redirectValid = 0;
    logic [31:0] validDest = 0, redirectPC = 0;
    logic fetchValid, inDs;
    logic [31:0] fetchPC, fifthPC;
    logic [3:0] originEnable;
    int total = 0, bad = 0;
    bit mBoot, mInDs;
    logic [31:0] mPC, mPend;

    always #5 clk = ~clk;

    fetch_pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .fetchReady_i(fetchReady), .fetchValid_o(fetchValid),
        .fetchPC_o(fetchPC), .originEnable_o(originEnable), .fifthPC_o(fifthPC),
        .inDelaySlot_o(inDs), .validDest_i(validDest), .validTake_i(validTake),
        .needDelaySlot_i(needDs), .redirectValid_i(redirectValid), .redirectPC_i(redirectPC)
    );

    function automatic logic [3:0] expEnable();
        logic [3:0] e = 0;
        if (mBoot) return 4'b0000;
        if (mInDs) return 4'b0001;
        for (int s = 0; s < 4; s++) if (s >= int'(mPC[3:2])) e[s] = 1'b1;
        return e;
    endfunction

    task automatic setIn(input logic r, input logic [31:0] d, input logic t, input logic n,
                         input logic rv, input logic [31:0] rp);
        fetchReady = r; validDest = d; validTake = t; needDs = n; redirectValid = rv; redirectPC = rp;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        if (redirectValid) begin
            mPC = redirectPC & ~32'd3; mBoot = 0; mInDs = 0; mPend = 0;
        end else if (mBoot) begin
            mBoot = 0;
        end else if (fetchReady) begin
            if (mInDs) begin
                mPC = mPend; mInDs = 0;
            end else if (needDs) begin
                mPend = validDest & ~32'd3; mPC = (mPC & ~32'd15) + 32'd16; mInDs = 1;
            end else begin
                mPC = validDest & ~32'd3;
            end
        end
        #1;
    endtask

    task automatic redirectTo(input logic [31:0] p);
        setIn(1, 32'h0, 0, 0, 1, p);
        tick();
    endtask

    task automatic test_reset();
        mBoot = 1; mInDs = 0; mPC = 32'hbfc00000; mPend = 0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (fetchValid !== 1'b0 || originEnable !== 4'b0 || inDs !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: valid=%b en=%b ds=%b want 0 0000 0", fetchValid, originEnable, inDs);
        end
        total++; if (fetchPC !== 32'hbfc00000) begin bad++; $display("FAIL reset_pc: got %h want bfc00000", fetchPC); end
        rst_n = 1;
        setIn(1, 32'hbfc00010, 0, 0, 0, 0);
        total++; if (fetchValid !== 1'b0) begin bad++; $display("FAIL boot_valid: got %b want 0", fetchValid); end
        tick();
        total++; if (fetchValid !== 1'b1 || fetchPC !== 32'hbfc00000 || originEnable !== 4'b1111) begin
            bad++; $display("FAIL boot_first: valid=%b pc=%h en=%b want 1 bfc00000 1111", fetchValid, fetchPC, originEnable);
        end
    endtask

    task automatic test_no_branch();
        setIn(1, 32'h0, 0, 0, 1, 32'hbfc00004);
        total++; if (fetchValid !== 1'b0) begin bad++; $display("FAIL redirect_valid: got %b want 0", fetchValid); end
        tick();
        setIn(1, 32'hbfc00010, 0, 0, 0, 0);
        total++; if (fetchPC !== 32'hbfc00004 || originEnable !== 4'b1110 || fifthPC !== 32'hbfc00010) begin
            bad++; $display("FAIL no_branch_group: pc=%h en=%b fifth=%h want bfc00004 1110 bfc00010", fetchPC, originEnable, fifthPC);
        end
        tick();
        total++; if (fetchPC !== 32'hbfc00010) begin bad++; $display("FAIL no_branch_next: got %h want bfc00010", fetchPC); end
    endtask

    task automatic test_taken();
        redirectTo(32'h80001000);
        setIn(1, 32'h80002000, 1, 0, 0, 0);
        tick();
        total++; if (fetchPC !== 32'h80002000 || inDs !== 1'b0 || originEnable !== 4'b1111) begin
            bad++; $display("FAIL taken: pc=%h ds=%b en=%b want 80002000 0 1111", fetchPC, inDs, originEnable);
        end
    endtask

    task automatic test_delay_slot();
        redirectTo(32'h80001000);
        setIn(1, 32'h80003000, 1, 1, 0, 0);
        tick();
        total++; if (fetchPC !== 32'h80001010 || originEnable !== 4'b0001 || inDs !== 1'b1) begin
            bad++; $display("FAIL dslot_enter: pc=%h en=%b ds=%b want 80001010 0001 1", fetchPC, originEnable, inDs);
        end
        setIn(1, 32'hdeadbee0, 1, 1, 0, 0);
        tick();
        total++; if (fetchPC !== 32'h80003000 || originEnable !== 4'b1111 || inDs !== 1'b0) begin
            bad++; $display("FAIL dslot_exit: pc=%h en=%b ds=%b want 80003000 1111 0", fetchPC, originEnable, inDs);
        end
    endtask

    task automatic test_stall_redirect();
        redirectTo(32'h80001000);
        setIn(1, 32'h80003000, 1, 1, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            setIn(0, 32'h12345670, 1, 0, 0, 0);
            total++; if (fetchValid !== 1'b1 || fetchPC !== 32'h80001010 || originEnable !== 4'b0001 || inDs !== 1'b1) begin
                bad++; $display("FAIL stall_hold[%0d]: valid=%b pc=%h en=%b ds=%b want 1 80001010 0001 1", i, fetchValid, fetchPC, originEnable, inDs);
            end
            tick();
        end
        setIn(1, 32'h0, 0, 0, 1, 32'hbfc00380);
        total++; if (fetchValid !== 1'b0) begin bad++; $display("FAIL dslot_redirect_valid: got %b want 0", fetchValid); end
        tick();
        total++; if (fetchPC !== 32'hbfc00380 || inDs !== 1'b0 || originEnable !== 4'b1111) begin
            bad++; $display("FAIL dslot_redirect: pc=%h ds=%b en=%b want bfc00380 0 1111", fetchPC, inDs, originEnable);
        end
        setIn(1, 32'hbfc00390, 0, 0, 0, 0);
        tick();
        total++; if (fetchPC !== 32'hbfc00390) begin bad++; $display("FAIL pend_dropped: got %h want bfc00390", fetchPC); end
    endtask

    task automatic test_wrap();
        redirectTo(32'hfffffffb);
        setIn(1, 32'h00000000, 0, 0, 0, 0);
        total++; if (fetchPC !== 32'hfffffff8 || fifthPC !== 32'h00000000 || originEnable !== 4'b1100) begin
            bad++; $display("FAIL wrap_group: pc=%h fifth=%h en=%b want fffffff8 00000000 1100", fetchPC, fifthPC, originEnable);
        end
        tick();
        total++; if (fetchPC !== 32'h00000000 || originEnable !== 4'b1111) begin
            bad++; $display("FAIL wrap_next: pc=%h en=%b want 00000000 1111", fetchPC, originEnable);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            setIn($urandom_range(3, 0) != 0, $urandom & ~32'd3, 1'($urandom), $urandom_range(3, 0) == 0,
                  $urandom_range(9, 0) == 0, $urandom);
            total++; if (fetchValid !== (!mBoot && !redirectValid) || fetchPC !== mPC || inDs !== mInDs ||
                         originEnable !== expEnable() || fifthPC !== (mPC & ~32'd15) + 32'd16) begin
                bad++; $display("FAIL random[%0d]: valid=%b pc=%h ds=%b en=%b fifth=%h want %b %h %b %b %h", i,
                                fetchValid, fetchPC, inDs, originEnable, fifthPC, !mBoot && !redirectValid, mPC,
                                mInDs, expEnable(), (mPC & ~32'd15) + 32'd16);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_no_branch();
        test_taken();
        test_delay_slot();
        test_stall_redirect();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
